// File: rtl/game_frame_compositor_if.sv
// Pixel-stream bundle between the game-logic stage and the compositor.
// slave = compositor side, master = upstream driver / output consumer.
interface game_frame_compositor_if;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        data_valid_in;
  logic        is_wall_in;
  logic        is_person_in;
  logic        is_collision_in;
  logic [7:0]  wall_depth_in;
  logic [7:0]  player_depth_in;
  logic [2:0]  game_state_in;
  logic [15:0] camera_pixel_in;
  logic [23:0] pixel_out;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        data_valid_out;
  logic [19:0] collision_count_out;
  logic        frame_done_out;
  logic        flash_active_out;

  modport slave (
    input  hcount_in, vcount_in, data_valid_in, is_wall_in, is_person_in,
           is_collision_in, wall_depth_in, player_depth_in, game_state_in,
           camera_pixel_in,
    output pixel_out, hcount_out, vcount_out, data_valid_out,
           collision_count_out, frame_done_out, flash_active_out
  );

  modport master (
    output hcount_in, vcount_in, data_valid_in, is_wall_in, is_person_in,
           is_collision_in, wall_depth_in, player_depth_in, game_state_in,
           camera_pixel_in,
    input  pixel_out, hcount_out, vcount_out, data_valid_out,
           collision_count_out, frame_done_out, flash_active_out
  );
endinterface

// File: rtl/game_frame_compositor.sv
// Two-stage RGB565 -> RGB888 compositor with wall shading, per-frame collision count
// and an optional loss-flash FSM enabled by macro GAME_FRAME_COMPOSITOR_FLASH_EN.
module game_frame_compositor #(
  parameter int unsigned SCREEN_WIDTH   = 1280,
  parameter int unsigned SCREEN_HEIGHT  = 720,
  parameter int unsigned MAX_WALL_DEPTH = 75,
  parameter int unsigned FLASH_FRAMES   = 30
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  game_frame_compositor_if.slave bus
);

  localparam logic [10:0] LAST_H = 11'(SCREEN_WIDTH - 1);
  localparam logic [9:0]  LAST_V = 10'(SCREEN_HEIGHT - 1);
  localparam logic [8:0]  MAX_D  = (MAX_WALL_DEPTH > 255) ? 9'd256 : 9'(MAX_WALL_DEPTH);

  logic        w_eof;
  logic        w_coll_hit;
  logic        w_flash_on;
  logic [7:0]  w_r8, w_g8, w_b8;
  logic [9:0]  w_depth3;
  logic [7:0]  w_shade;
  logic [23:0] w_colour;
  logic        w_unused;

  logic        r_s1_valid, r_s1_wall, r_s1_person, r_s1_coll, r_s1_won, r_s1_flash;
  logic [10:0] r_s1_h;
  logic [9:0]  r_s1_v;
  logic [7:0]  r_s1_r, r_s1_g, r_s1_b, r_s1_shade;

  logic [23:0] r_pixel;
  logic [10:0] r_hcount;
  logic [9:0]  r_vcount;
  logic        r_valid;
  logic [19:0] r_acc;
  logic [19:0] r_coll_count;
  logic        r_frame_done;

  assign w_unused   = ^bus.player_depth_in;
  assign w_eof      = bus.data_valid_in && (bus.hcount_in == LAST_H) && (bus.vcount_in == LAST_V);
  assign w_coll_hit = bus.data_valid_in && bus.is_collision_in;

  assign w_r8 = {bus.camera_pixel_in[15:11], bus.camera_pixel_in[15:13]};
  assign w_g8 = {bus.camera_pixel_in[10:5],  bus.camera_pixel_in[10:9]};
  assign w_b8 = {bus.camera_pixel_in[4:0],   bus.camera_pixel_in[4:2]};

  assign w_depth3 = {2'b00, bus.wall_depth_in} + {1'b0, bus.wall_depth_in, 1'b0};
  assign w_shade  = (({1'b0, bus.wall_depth_in} >= MAX_D) || (w_depth3 > 10'd255))
                    ? 8'hFF : w_depth3[7:0];

`ifdef GAME_FRAME_COMPOSITOR_FLASH_EN
  typedef enum logic [1:0] {IDLE, FLASH, HOLD} flash_state_t;
  localparam logic [7:0] LAST_FRAME = 8'(FLASH_FRAMES - 1);

  flash_state_t r_state, w_state_nxt;
  logic [7:0]   r_frame_cnt, w_frame_cnt_nxt;
  logic [2:0]   r_prev_gs;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state     <= IDLE;
      r_frame_cnt <= '0;
      r_prev_gs   <= 3'd1;
    end else begin
      r_state     <= w_state_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_prev_gs   <= bus.game_state_in;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_frame_cnt_nxt = r_frame_cnt;
    case (r_state)
      IDLE: if (bus.game_state_in == 3'd0 && r_prev_gs != 3'd0) begin
        w_state_nxt     = FLASH;
        w_frame_cnt_nxt = '0;
      end
      FLASH: begin
        if (bus.game_state_in != 3'd0) w_state_nxt = IDLE;
        else if (w_eof) begin
          if (r_frame_cnt == LAST_FRAME) w_state_nxt = HOLD;
          else w_frame_cnt_nxt = r_frame_cnt + 8'd1;
        end
      end
      HOLD: if (bus.game_state_in != 3'd0) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_flash_on           = (r_state == FLASH) && !r_frame_cnt[2];
  assign bus.flash_active_out = (r_state == FLASH);
`else
  assign w_flash_on           = 1'b0;
  assign bus.flash_active_out = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_s1_valid  <= 1'b0;
      r_s1_h      <= '0;
      r_s1_v      <= '0;
      r_s1_r      <= '0;
      r_s1_g      <= '0;
      r_s1_b      <= '0;
      r_s1_shade  <= '0;
      r_s1_wall   <= 1'b0;
      r_s1_person <= 1'b0;
      r_s1_coll   <= 1'b0;
      r_s1_won    <= 1'b0;
      r_s1_flash  <= 1'b0;
    end else begin
      r_s1_valid  <= bus.data_valid_in;
      r_s1_h      <= bus.hcount_in;
      r_s1_v      <= bus.vcount_in;
      r_s1_r      <= w_r8;
      r_s1_g      <= w_g8;
      r_s1_b      <= w_b8;
      r_s1_shade  <= w_shade;
      r_s1_wall   <= bus.is_wall_in;
      r_s1_person <= bus.is_person_in;
      r_s1_coll   <= bus.is_collision_in;
      r_s1_won    <= (bus.game_state_in == 3'd2);
      r_s1_flash  <= w_flash_on;
    end
  end

  always_comb begin
    w_colour = {r_s1_r, r_s1_g, r_s1_b};
    if (r_s1_flash || r_s1_coll)           w_colour = 24'hFF0000;
    else if (r_s1_wall && r_s1_person)     w_colour = {r_s1_shade, 8'h00, r_s1_b};
    else if (r_s1_wall)                    w_colour = {16'h0000, r_s1_shade};
    else if (r_s1_won && !r_s1_person)     w_colour = {r_s1_r, 8'hFF, r_s1_b};
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_pixel  <= '0;
      r_hcount <= '0;
      r_vcount <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_pixel  <= r_s1_valid ? w_colour : '0;
      r_hcount <= r_s1_h;
      r_vcount <= r_s1_v;
      r_valid  <= r_s1_valid;
    end
  end

  // The end-of-frame pixel's own collision is folded into the published total.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_acc        <= '0;
      r_coll_count <= '0;
      r_frame_done <= 1'b0;
    end else if (w_eof) begin
      r_coll_count <= r_acc + 20'(w_coll_hit);
      r_acc        <= '0;
      r_frame_done <= 1'b1;
    end else begin
      r_acc        <= r_acc + 20'(w_coll_hit);
      r_frame_done <= 1'b0;
    end
  end

  assign bus.pixel_out           = r_pixel;
  assign bus.hcount_out          = r_hcount;
  assign bus.vcount_out          = r_vcount;
  assign bus.data_valid_out      = r_valid;
  assign bus.collision_count_out = r_coll_count;
  assign bus.frame_done_out      = r_frame_done;

endmodule

// File: doc/game_frame_compositor.md
GAME_FRAME_COMPOSITOR -- requirements
Module: game_frame_compositor

Interface
REQ-001 SHALL have parameter SCREEN_WIDTH, default 1280: active pixels per line.
REQ-002 SHALL have parameter SCREEN_HEIGHT, default 720: active lines per frame.
REQ-003 SHALL have parameter MAX_WALL_DEPTH, default 75: wall depth at which wall shade saturates.
REQ-004 SHALL have parameter FLASH_FRAMES, default 30: frame count of the loss flash.
REQ-005 SHALL have port clk_in, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_in, input, 1: asynchronous active-low reset.
REQ-007 SHALL have ports hcount_in (input, 11) and vcount_in (input, 10): pixel coordinate from the upstream game logic stage.
REQ-008 SHALL have port data_valid_in, input, 1: the coordinate and flags are an active pixel.
REQ-009 SHALL have ports is_wall_in, is_person_in and is_collision_in, input, 1 each: per-pixel classification.
REQ-010 SHALL have ports wall_depth_in and player_depth_in, input, 8 each: depths in inches.
REQ-011 SHALL have port game_state_in, input, 3: 0 = lost, 1 = playing/idle, 2 = won.
REQ-012 SHALL have port camera_pixel_in, input, 16: RGB565 camera pixel aligned with hcount_in.
REQ-013 SHALL have port pixel_out, output, 24: RGB888 composited pixel.
REQ-014 SHALL have ports hcount_out (output, 11), vcount_out (output, 10) and data_valid_out (output, 1): the coordinate and valid flag, delayed to match pixel_out.
REQ-015 SHALL have port collision_count_out, output, 20: collision pixel total of the last complete frame.
REQ-016 SHALL have port frame_done_out, output, 1: one-cycle pulse when collision_count_out updates.
REQ-017 SHALL have port flash_active_out, output, 1: the loss flash is in progress.

Function
REQ-018 SHALL be a 2-stage pipeline: pixel_out, hcount_out, vcount_out and data_valid_out for an input accepted at cycle N SHALL appear at cycle N+2, every cycle, with no stall.
REQ-019 SHALL compute, in stage 1, expansion = {R5,R5[4:2]}, {G6,G6[5:4]}, {B5,B5[4:2]}.
REQ-020 SHALL compute, in stage 1, shade = min(wall_depth_in*3, 255); when wall_depth_in >= MAX_WALL_DEPTH, shade SHALL be 255.
REQ-021 SHALL select the stage-2 colour by first match: flash on-phase -> FF0000; is_collision -> FF0000; wall and person -> {shade,0,expanded B}; wall -> {0,0,shade}; game_state_in==2 and not person -> {expanded R,FF,expanded B}; otherwise the expanded camera pixel.
REQ-022 SHALL drive pixel_out to 000000 when the delayed data_valid is 0.
REQ-023 SHALL increment a 20-bit accumulator on each cycle where data_valid_in && is_collision_in.
REQ-024 SHALL treat the end-of-frame pixel as hcount_in==SCREEN_WIDTH-1 && vcount_in==SCREEN_HEIGHT-1 && data_valid_in.
REQ-025 SHALL, on the cycle after the end-of-frame pixel, load collision_count_out with the accumulator (including that pixel), clear the accumulator, and pulse frame_done_out.
REQ-026 SHALL implement the flash FSM with states IDLE, FLASH and HOLD.
REQ-027 SHALL move IDLE -> FLASH when game_state_in==0 and the registered previous game_state_in != 0, clearing the frame counter.
REQ-028 SHALL, in FLASH, increment the frame counter on each end-of-frame pixel; the on-phase SHALL be frame counter bit 2 == 0.
REQ-029 SHALL move FLASH -> HOLD when the frame counter reaches FLASH_FRAMES-1 at an end-of-frame pixel.
REQ-030 SHALL move HOLD -> IDLE, and FLASH -> IDLE, when game_state_in != 0.
REQ-031 SHALL assert flash_active_out only in FLASH.

Reset
REQ-032 SHALL, while rst_in is low, immediately clear every pipeline register, the accumulator, pixel_out, hcount_out, vcount_out, data_valid_out, collision_count_out, frame_done_out and flash_active_out, and set the FSM to IDLE with the previous-state register at 1.
REQ-033 SHALL discard the partial frame count on a reset mid-frame; the first frame_done_out after deassertion SHALL follow the next end-of-frame pixel.

Configuration
REQ-034 SHALL compile the flash FSM in only when macro GAME_FRAME_COMPOSITOR_FLASH_EN is defined; when it is undefined, the FSM SHALL be absent, flash_active_out SHALL be constant 0 and the flash priority entry SHALL never match.

Verification
REQ-035 SHALL cover: camera F800 at (10,10), no flags -> pixel_out FF0000 exactly 2 cycles later, hcount_out 10.
REQ-036 SHALL cover: is_wall, wall_depth 40 -> 0000x78; wall_depth 90 -> 0000FF.
REQ-037 SHALL cover: 500 collision pixels in one frame -> collision_count_out 500 with a single frame_done_out pulse after (1279,719); the next frame with 0 collisions -> 0.
REQ-038 SHALL cover: game_state_in 1 -> 0 with the macro defined -> flash_active_out high for exactly 30 frames with FF0000 on frames 0-3, 8-11, ... then HOLD; game_state_in -> 1 -> IDLE.
REQ-039 SHALL cover: rst_in low mid-frame after 100 collisions -> all outputs 0 asynchronously; next frame with 7 collisions -> 7.
REQ-040 SHALL cover: the macro undefined, same stimulus as REQ-038 -> flash_active_out constant 0 and no flash colour.
